// File: rtl/bcd_pkg.sv
// Shared BCD digit type, range constants and the load-clamp helper used by the
// tick-driven BCD counter.
package bcd_pkg;

  typedef logic [3:0] bcd_digit_t;

  localparam bcd_digit_t BCD_MAX = 4'd9;
  localparam bcd_digit_t BCD_MIN = 4'd0;

  // Non-BCD nibbles (A..F) are forced to the largest legal digit.
  function automatic bcd_digit_t bcd_clamp(input bcd_digit_t d);
    return (d > BCD_MAX) ? BCD_MAX : d;
  endfunction

endpackage

// File: rtl/bcd_digit.sv
// One BCD digit register with a carry/borrow ripple in and out.
// Down counting exists only when TICK_BCD_COUNTER_DOWN_EN is defined.
module bcd_digit
  import bcd_pkg::*;
(
  input  logic       clk_i,
  input  logic       reset_ni,
  input  logic       clear_i,
  input  logic       load_i,
  input  logic [3:0] load_digit_i,
  input  logic       up_i,
  input  logic       cin_i,
  output logic       cout_o,
  output logic [3:0] digit_o,
  output logic       at_max_o,
  output logic       at_min_o
);

  bcd_digit_t digit_q;
  bcd_digit_t step_d;

  // cin_i means "this digit steps this cycle"; cout_o passes the step on
  // when the digit rolls over, so the whole chain settles within one cycle.
  always_comb begin
    step_d = digit_q;
    cout_o = 1'b0;
`ifdef TICK_BCD_COUNTER_DOWN_EN
    if (up_i) begin
      cout_o = cin_i & (digit_q == BCD_MAX);
      step_d = (digit_q == BCD_MAX) ? BCD_MIN : digit_q + 4'd1;
    end else begin
      cout_o = cin_i & (digit_q == BCD_MIN);
      step_d = (digit_q == BCD_MIN) ? BCD_MAX : digit_q - 4'd1;
    end
`else
    cout_o = cin_i & (digit_q == BCD_MAX);
    step_d = (digit_q == BCD_MAX) ? BCD_MIN : digit_q + 4'd1;
`endif
  end

`ifndef TICK_BCD_COUNTER_DOWN_EN
  logic unused_up;
  assign unused_up = up_i;
`endif

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni)    digit_q <= BCD_MIN;
    else if (clear_i) digit_q <= BCD_MIN;
    else if (load_i)  digit_q <= bcd_clamp(load_digit_i);
    else if (cin_i)   digit_q <= step_d;
  end

  assign digit_o  = digit_q;
  assign at_max_o = (digit_q == BCD_MAX);
  assign at_min_o = (digit_q == BCD_MIN);

endmodule

// File: rtl/tick_bcd_counter.sv
// Multi-digit BCD counter advanced by an upstream tick strobe; wraps or
// saturates at the range limit. Define TICK_BCD_COUNTER_DOWN_EN for up/down.
module tick_bcd_counter
  import bcd_pkg::*;
#(
  parameter int DIGITS_N = 4,
  parameter int WRAP     = 1
) (
  input  logic                  clk_i,
  input  logic                  reset_ni,
  input  logic                  tick_i,
  input  logic                  enable_i,
  input  logic                  clear_i,
  input  logic                  load_i,
  input  logic [4*DIGITS_N-1:0] load_value_i,
  input  logic                  up_i,
  output logic [4*DIGITS_N-1:0] digits_o,
  output logic                  carry_o,
  output logic                  at_limit_o
);

  if (DIGITS_N < 1 || DIGITS_N > 8) begin : g_bad_digits
    $error("tick_bcd_counter: DIGITS_N must be 1..8");
  end

  logic                dir_up;
  logic                tick_qual;
  logic                limit_hit;
  logic                carry_q;
  logic [DIGITS_N:0]   chain;
  logic [DIGITS_N-1:0] at_max;
  logic [DIGITS_N-1:0] at_min;

`ifdef TICK_BCD_COUNTER_DOWN_EN
  assign dir_up = up_i;
`else
  logic unused_up;
  assign unused_up = up_i;
  assign dir_up    = 1'b1;
`endif

  // Clear and load outrank the tick, so a tick in the same cycle is dropped.
  assign tick_qual  = tick_i & enable_i & ~clear_i & ~load_i;
  assign at_limit_o = dir_up ? (&at_max) : (&at_min);
  assign limit_hit  = tick_qual & at_limit_o;

  // In saturate mode a tick at the limit never enters the chain.
  assign chain[0] = tick_qual & ~(limit_hit & (WRAP == 0));

  for (genvar i = 0; i < DIGITS_N; i++) begin : g_digit
    bcd_digit u_digit (
      .clk_i        (clk_i),
      .reset_ni     (reset_ni),
      .clear_i      (clear_i),
      .load_i       (load_i),
      .load_digit_i (load_value_i[4*i +: 4]),
      .up_i         (dir_up),
      .cin_i        (chain[i]),
      .cout_o       (chain[i+1]),
      .digit_o      (digits_o[4*i +: 4]),
      .at_max_o     (at_max[i]),
      .at_min_o     (at_min[i])
    );
  end

  logic unused_chain_top;
  assign unused_chain_top = chain[DIGITS_N];

  // Pulses in the cycle the wrapped (or held) value is presented.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) carry_q <= 1'b0;
    else           carry_q <= limit_hit;
  end

  assign carry_o = carry_q;

endmodule

// File: tb/tb_tick_bcd_counter.sv
// Directed bench: one wrapping and one saturating counter share all inputs.
module tb_tick_bcd_counter;

  logic        clk_i = 1'b0;
  logic        reset_ni;
  logic        tick_i, enable_i, clear_i, load_i, up_i;
  logic [15:0] load_value_i;
  logic [15:0] dig_w, dig_s;
  logic        car_w, car_s, lim_w, lim_s;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk_i = ~clk_i;

  tick_bcd_counter #(.DIGITS_N(4), .WRAP(1)) u_wrap (
    .clk_i(clk_i), .reset_ni(reset_ni), .tick_i(tick_i), .enable_i(enable_i),
    .clear_i(clear_i), .load_i(load_i), .load_value_i(load_value_i), .up_i(up_i),
    .digits_o(dig_w), .carry_o(car_w), .at_limit_o(lim_w)
  );

  tick_bcd_counter #(.DIGITS_N(4), .WRAP(0)) u_sat (
    .clk_i(clk_i), .reset_ni(reset_ni), .tick_i(tick_i), .enable_i(enable_i),
    .clear_i(clear_i), .load_i(load_i), .load_value_i(load_value_i), .up_i(up_i),
    .digits_o(dig_s), .carry_o(car_s), .at_limit_o(lim_s)
  );

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Advance one clock and settle just past the edge.
  task automatic cyc();
    @(posedge clk_i);
    #1;
  endtask

  task automatic do_load(input logic [15:0] v);
    load_i = 1'b1; load_value_i = v;
    cyc();
    load_i = 1'b0;
  endtask

  task automatic do_tick();
    tick_i = 1'b1;
    cyc();
    tick_i = 1'b0;
  endtask

  initial begin
    reset_ni = 1'b0; tick_i = 1'b0; enable_i = 1'b1; clear_i = 1'b0;
    load_i = 1'b0; up_i = 1'b1; load_value_i = 16'h0;
    cyc(); cyc();
    chk("rst_digits", dig_w, 16'h0000);
    chk("rst_carry",  car_w, 1'b0);
    chk("rst_limit",  lim_w, 1'b0);
    reset_ni = 1'b1;
    cyc();

    // first tick after release counts from zero
    do_tick();
    chk("first_tick", dig_w, 16'h0001);

    // ripple
    do_load(16'h0199);
    chk("load_0199", dig_w, 16'h0199);
    do_tick();
    chk("ripple_0200", dig_w, 16'h0200);
    do_load(16'h0999);
    do_tick();
    chk("ripple_1000", dig_w, 16'h1000);

    // wrap vs saturate, single tick
    do_load(16'h9999);
    chk("lim_9999", lim_w, 1'b1);
    do_tick();
    chk("wrap_digits", dig_w, 16'h0000);
    chk("wrap_carry",  car_w, 1'b1);
    chk("sat1_digits", dig_s, 16'h9999);
    cyc();
    chk("wrap_carry_end", car_w, 1'b0);

    // saturate: three back-to-back ticks
    do_load(16'h9999);
    tick_i = 1'b1;
    for (int k = 0; k < 3; k++) begin
      cyc();
      chk("sat_digits", dig_s, 16'h9999);
      chk("sat_carry",  car_s, 1'b1);
      chk("sat_limit",  lim_s, 1'b1);
    end
    tick_i = 1'b0;
    cyc();
    chk("sat_carry_end", car_s, 1'b0);
    chk("sat_limit_end", lim_s, 1'b1);

    // priority
    clear_i = 1'b1; load_i = 1'b1; load_value_i = 16'h1234; tick_i = 1'b1;
    cyc();
    clear_i = 1'b0;
    chk("prio_clear", dig_w, 16'h0000);
    chk("prio_carry", car_w, 1'b0);
    load_value_i = 16'h12F4;
    cyc();
    load_i = 1'b0; tick_i = 1'b0;
    chk("prio_load_clamp", dig_w, 16'h1294);

    // enable gating: 6 ticks 50 cycles apart, two while disabled
    clear_i = 1'b1; cyc(); clear_i = 1'b0;
    for (int t = 0; t < 6; t++) begin
      for (int k = 0; k < 49; k++) cyc();
      enable_i = (t == 1 || t == 3) ? 1'b0 : 1'b1;
      do_tick();
      enable_i = 1'b1;
    end
    chk("enable_count", dig_w, 16'h0004);

    // held tick counts every cycle
    tick_i = 1'b1; cyc(); cyc(); cyc(); tick_i = 1'b0;
    chk("held_tick", dig_w, 16'h0007);

    // asynchronous reset mid-cycle
    do_load(16'h0042);
    chk("pre_rst", dig_w, 16'h0042);
    #2 reset_ni = 1'b0;
    #1;
    chk("async_rst_digits", dig_w, 16'h0000);
    chk("async_rst_carry",  car_w, 1'b0);
    cyc();
    reset_ni = 1'b1;

    // reset while a full ripple is pending
    do_load(16'h0999);
    tick_i = 1'b1;
    #2 reset_ni = 1'b0;
    cyc();
    tick_i = 1'b0;
    chk("rst_midchain", dig_w, 16'h0000);
    reset_ni = 1'b1;
    cyc();

`ifdef TICK_BCD_COUNTER_DOWN_EN
    up_i = 1'b0;
    #1;
    chk("down_lim_0000", lim_w, 1'b1);
    do_tick();
    chk("down_wrap_digits", dig_w, 16'h9999);
    chk("down_wrap_carry",  car_w, 1'b1);
    chk("down_sat_digits",  dig_s, 16'h0000);
    chk("down_sat_carry",   car_s, 1'b1);
    cyc();
    chk("down_carry_end", car_w, 1'b0);
    do_load(16'h1000);
    do_tick();
    chk("borrow_0999", dig_w, 16'h0999);
    up_i = 1'b1;
    do_tick();
    chk("dir_change_1000", dig_w, 16'h1000);
`else
    up_i = 1'b0;
    #1;
    chk("updown_off_limit", lim_w, 1'b0);
    do_tick();
    chk("updown_off_inc", dig_w, 16'h0001);
    chk("updown_off_carry", car_w, 1'b0);
    up_i = 1'b1;
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
